// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator.
//   - mode_e       : pattern select encoding
//   - DEF_*        : default 640x480@60 timing (25 MHz pixel clock)
//   - COLOR_*      : full-scale RGB565 colour constants
//   - BAR_COLORS   : colour-bar order, index 0 is the leftmost bar
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GRID    = 2'd3
  } mode_e;

  // Default 640x480@60 timing
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_CELL_SHIFT = 5;

  // RGB565 colours, full-scale components
  localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
  localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;
  localparam logic [15:0] COLOR_RED     = 16'hF800;
  localparam logic [15:0] COLOR_BLUE    = 16'h001F;
  localparam logic [15:0] COLOR_BLACK   = 16'h0000;

  // Packed so that element [0] is the leftmost bar (white)
  localparam logic [7:0][15:0] BAR_COLORS = {
    COLOR_BLACK, COLOR_BLUE, COLOR_RED, COLOR_MAGENTA,
    COLOR_GREEN, COLOR_CYAN, COLOR_YELLOW, COLOR_WHITE
  };

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters,
// sync and DE generation, and blanking-gated pixel coordinates.
//
// Ports
//   clk, rst_n      : system clock, asynchronous active-low reset
//   pix_en          : one-clock pixel strobe (always high when CLK_DIV=1)
//   h_cnt, v_cnt    : raw raster counters (current pixel, unregistered view)
//   active          : h_cnt/v_cnt lie inside the visible area (combinational)
//   hsync, vsync    : registered sync outputs, polarity set by HS_POL/VS_POL
//   de              : registered active-video qualifier
//   x, y            : registered coordinate, zero during blanking
//   frame_start     : registered, high for the whole pixel period of (0,0)
//
// The registered outputs load on pix_en from the counter value present in
// that same cycle, so they lag the counters by one clock and stay mutually
// aligned with anything else registered on pix_en from the same counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = $clog2(H_TOTAL),
  localparam int V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           pix_en,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           frame_start
);

  // A 1-bit counter pinned at 0 covers CLK_DIV=1: it always equals DIV_LAST.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [H_W-1:0]   h_cnt_reg;
  logic [V_W-1:0]   v_cnt_reg;
  logic             hsync_reg, vsync_reg, de_reg, frame_start_reg;
  logic [H_W-1:0]   x_reg;
  logic [V_W-1:0]   y_reg;

  logic h_sync_now, v_sync_now;

  assign pix_en = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (pix_en) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + V_W'(1);
      end else begin
        h_cnt_reg <= h_cnt_reg + H_W'(1);
      end
    end
  end

  assign h_cnt      = h_cnt_reg;
  assign v_cnt      = v_cnt_reg;
  assign active     = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
  assign h_sync_now = (h_cnt_reg >= H_SYNC_FIRST) && (h_cnt_reg <= H_SYNC_LAST);
  assign v_sync_now = (v_cnt_reg >= V_SYNC_FIRST) && (v_cnt_reg <= V_SYNC_LAST);

  // Sync outputs rest at their inactive level, including during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      de_reg          <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      frame_start_reg <= 1'b0;
    end else if (pix_en) begin
      hsync_reg       <= h_sync_now ? HS_POL : ~HS_POL;
      vsync_reg       <= v_sync_now ? VS_POL : ~VS_POL;
      de_reg          <= active;
      x_reg           <= active ? h_cnt_reg : '0;
      y_reg           <= active ? v_cnt_reg : '0;
      frame_start_reg <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: raster timing plus four selectable patterns
// (solid, colour bars, checker, grid) on an RGB565 output.
//
// Ports
//   clk, rst_n          : system clock, asynchronous active-low reset
//   mode                : pattern select, sampled once per frame at (0,0)
//   solid_color         : RGB565 for solid mode / grid background, sampled
//                         together with mode
//   R, G, B             : registered RGB565 pixel, zero while DE is low
//   HSYNC, VSYNC        : registered syncs
//   DE                  : registered active-video qualifier
//   x, y                : registered coordinate aligned with DE
//   frame_start         : high for the pixel period of (0,0)
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CELL_SHIFT = DEF_CELL_SHIFT,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W       = $clog2(H_TOTAL),
  localparam int V_W       = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     mode,
  input  logic [15:0]    solid_color,
  output logic [4:0]     R,
  output logic [5:0]     G,
  output logic [4:0]     B,
  output logic           HSYNC,
  output logic           VSYNC,
  output logic           DE,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);

  logic           pix_en;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           active;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hsync       (HSYNC),
    .vsync       (VSYNC),
    .de          (DE),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  // ---------------------------------------------------------------------
  // Per-frame mode/colour latch. Pixel (0,0) itself already uses the newly
  // sampled inputs, so the effective selection bypasses the latch there.
  // ---------------------------------------------------------------------
  mode_e       mode_reg;
  logic [15:0] color_reg;
  logic        frame_origin;
  mode_e       eff_mode;
  logic [15:0] eff_color;

  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
  assign eff_mode     = frame_origin ? mode_e'(mode) : mode_reg;
  assign eff_color    = frame_origin ? solid_color : color_reg;

  // ---------------------------------------------------------------------
  // Colour bars: one comparator per bar edge; the number of edges already
  // passed is the bar index. Index 8 means the remainder pixels past the
  // last full bar, which are black.
  // ---------------------------------------------------------------------
  logic [7:0]  bar_ge;
  logic [3:0]  bar_idx;
  logic [15:0] bar_color;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bar_edge
      assign bar_ge[gi] = (h_cnt >= H_W'((gi + 1) * BAR_W));
    end
  endgenerate

  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < 8; i++) begin
      bar_idx = bar_idx + {3'b000, bar_ge[i]};
    end
  end

  assign bar_color = bar_idx[3] ? COLOR_BLACK : BAR_COLORS[bar_idx[2:0]];

  // ---------------------------------------------------------------------
  // Checker and grid use the raw counters; inside active video these equal
  // the x/y coordinate, and outside it the result is masked to black.
  // ---------------------------------------------------------------------
  logic checker_white;
  logic grid_line;

  assign checker_white = h_cnt[CELL_SHIFT] ^ v_cnt[CELL_SHIFT];
  assign grid_line     = (h_cnt[CELL_SHIFT-1:0] == '0) ||
                         (v_cnt[CELL_SHIFT-1:0] == '0) ||
                         (h_cnt == H_ACT_LAST) ||
                         (v_cnt == V_ACT_LAST);

  logic [15:0] pattern_color;

  always_comb begin
    pattern_color = COLOR_BLACK;
    case (eff_mode)
      MODE_SOLID:   pattern_color = eff_color;
      MODE_BARS:    pattern_color = bar_color;
      MODE_CHECKER: pattern_color = checker_white ? COLOR_WHITE : COLOR_BLACK;
      MODE_GRID:    pattern_color = grid_line ? COLOR_WHITE : eff_color;
      default:      pattern_color = COLOR_BLACK;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output pixel register, loaded on the same pix_en as the timing outputs.
  // ---------------------------------------------------------------------
  logic [15:0] rgb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= MODE_SOLID;
      color_reg <= '0;
      rgb_reg   <= '0;
    end else if (pix_en) begin
      if (frame_origin) begin
        mode_reg  <= mode_e'(mode);
        color_reg <= solid_color;
      end
      rgb_reg <= active ? pattern_color : COLOR_BLACK;
    end
  end

  assign R = rgb_reg[15:11];
  assign G = rgb_reg[10:5];
  assign B = rgb_reg[4:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a reduced raster so several full
// frames fit in a short run. A reference model predicts every pixel from
// the raster rules and pushes it into a queue; a monitor pops and compares
// one entry per pixel period.
module tb_vga_pattern_gen;

  localparam int CD   = 3;
  localparam int HA   = 66;   // not a multiple of 8: two black remainder pixels
  localparam int HFP  = 4;
  localparam int HSW  = 8;
  localparam int HBP  = 4;
  localparam int VA   = 32;
  localparam int VFP  = 2;
  localparam int VSW  = 2;
  localparam int VBP  = 3;
  localparam int CS   = 3;
  localparam bit HSP  = 1'b1;
  localparam bit VSP  = 1'b0;
  localparam int HT   = HA + HFP + HSW + HBP;
  localparam int VT   = VA + VFP + VSW + VBP;
  localparam int FL   = HT * VT;
  localparam int HW   = $clog2(HT);
  localparam int VW   = $clog2(VT);
  localparam int NF   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   solid_color = 16'h0;
  logic [4:0]    R;
  logic [5:0]    G;
  logic [4:0]    B;
  logic          HSYNC, VSYNC, DE, frame_start;
  logic [HW-1:0] x;
  logic [VW-1:0] y;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CELL_SHIFT(CS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_color(solid_color),
    .R(R), .G(G), .B(B), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
    .x(x), .y(y), .frame_start(frame_start)
  );

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic [15:0]   rgb;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Bar colours written from their names: white, yellow, cyan, green,
  // magenta, red, blue, black.
  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] ref_color(input int m, input logic [15:0] c,
                                            input int h, input int v);
    int bw;
    bw = HA / 8;
    case (m)
      0: return c;
      1: return (h / bw < 8) ? bar_tab[h / bw] : 16'h0000;
      2: return ((((h >> CS) ^ (v >> CS)) & 1) == 1) ? 16'hFFFF : 16'h0000;
      default: return ((h % (1 << CS) == 0) || (v % (1 << CS) == 0) ||
                       (h == HA - 1) || (v == VA - 1)) ? 16'hFFFF : c;
    endcase
  endfunction

  // Reference model: counts system clocks since reset release; every CD-th
  // clock is a new pixel whose expected outputs are pushed to the queue.
  initial begin
    int          clk_cnt;
    int          pix_n;
    int          h, v;
    int          lat_mode;
    logic [15:0] lat_color;
    pix_t        e;
    clk_cnt = 0; pix_n = 0; lat_mode = 0; lat_color = 16'h0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        clk_cnt = 0;
        pix_n   = 0;
        exp_q.delete();
      end else begin
        if (clk_cnt % CD == CD - 1) begin
          h = pix_n % HT;
          v = (pix_n / HT) % VT;
          if (h == 0 && v == 0) begin
            lat_mode  = int'(mode);
            lat_color = solid_color;
          end
          e.de  = (h < HA) && (v < VA);
          e.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : ~HSP;
          e.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? VSP : ~VSP;
          e.fs  = (h == 0) && (v == 0);
          e.x   = e.de ? HW'(h) : '0;
          e.y   = e.de ? VW'(v) : '0;
          e.rgb = e.de ? ref_color(lat_mode, lat_color, h, v) : 16'h0000;
          exp_q.push_back(e);
          pix_n++;
        end
        clk_cnt++;
      end
    end
  end

  // Monitor: outputs are updated on a posedge; compare at the next negedge.
  initial begin
    pix_t e, a;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{de: DE, hs: HSYNC, vs: VSYNC, fs: frame_start, x: x, y: y,
              rgb: {R, G, B}};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL pixel @%0t: got de=%b hs=%b vs=%b fs=%b x=%0d y=%0d rgb=%h, expected de=%b hs=%b vs=%b fs=%b x=%0d y=%0d rgb=%h",
                   $time, a.de, a.hs, a.vs, a.fs, a.x, a.y, a.rgb,
                   e.de, e.hs, e.vs, e.fs, e.x, e.y, e.rgb);
        end
      end
    end
  end

  task automatic wait_pix(input int k);
    repeat (k * CD) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_de"}, {31'd0, DE}, 32'd0);
    check({tag, "_rgb"}, {16'd0, R, G, B}, 32'd0);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
    check({tag, "_hsync"}, {31'd0, HSYNC}, {31'd0, ~HSP});
    check({tag, "_vsync"}, {31'd0, VSYNC}, {31'd0, ~VSP});
  endtask

  initial begin
    int plan [NF] = '{1, 2, 3, 0, 3, 1};
    int mid;
    int cnt;
    bit found;

    mode        = 2'(plan[0]);
    solid_color = 16'(
$urandom);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    for (int f = 0; f < NF; f++) begin
      $display("frame %0d: mode %0d colour %h", f, mode, solid_color);
      mid = int'($urandom_range(10, FL - 30));
      wait_pix(mid);
      // Mid-frame change: must not show until the next frame start.
      mode        = 2'($urandom_range(0, 3));
      solid_color = 16'($urandom);
      $display("frame %0d: mid-frame change at pixel %0d to mode %0d colour %h",
               f, mid, mode, solid_color);
      wait_pix(FL - 10 - mid);
      if (f < NF - 1) begin
        mode        = 2'(plan[f + 1]);
        solid_color = 16'($urandom);
      end
      wait_pix(10);
    end

    // Land inside the horizontal sync of line 0, then reset asynchronously.
    wait_pix(73);
    check("pre_reset_hsync", {31'd0, HSYNC}, {31'd0, HSP});
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-line at %0t", $time);
    check_cleared("async_reset");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // First active HSYNC must appear for pixel HA+HFP of line 0.
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (HSYNC == HSP) found = 1'b1;
    end
    check("first_hsync_found", {31'd0, found}, 32'd1);
    check("first_hsync_clocks", 32'(cnt), 32'(CD * (HA + HFP) + CD));
    $display("after reset: first HSYNC after %0d clocks", cnt);

    wait_pix(2 * HT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel (1..16; 50 MHz/2 = 25 MHz pixel rate).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical timing in lines.
REQ-004 SHALL have parameters HS_POL 0 and VS_POL 0, meaning sync active level (0 = active-low).
REQ-005 SHALL have parameter CELL_SHIFT, default 5, meaning log2 of the checker/grid cell size in pixels.
REQ-006 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port mode, input, 2 bits: pattern select (0 solid, 1 colour bars, 2 checker, 3 grid).
REQ-009 SHALL have port solid_color, input, 16 bits: RGB565 colour for solid mode and the grid background.
REQ-010 SHALL have ports R (5), G (6), B (5) as outputs carrying RGB565 pixel data.
REQ-011 SHALL have ports HSYNC and VSYNC as 1-bit outputs carrying the sync signals.
REQ-012 SHALL have port DE, output, 1 bit: active-video qualifier.
REQ-013 SHALL have ports x (clog2(H_TOTAL) bits) and y (clog2(V_TOTAL) bits) as outputs giving the pixel coordinate aligned with DE.
REQ-014 SHALL have port frame_start, output, 1 bit: pulse of one pixel period (CLK_DIV clocks) at pixel (0,0).

Function
REQ-015 SHALL derive H_TOTAL and V_TOTAL as the sum of their four timing parameters (defaults 800 and 525).
REQ-016 SHALL generate pix_en from a divide counter 0..CLK_DIV-1; pix_en asserts when the counter equals CLK_DIV-1; CLK_DIV=1 keeps pix_en permanently high.
REQ-017 SHALL advance h_cnt on pix_en, wrapping from H_TOTAL-1 to 0; on that wrap v_cnt SHALL advance, wrapping from V_TOTAL-1 to 0.
REQ-018 SHALL order each line/frame as active, front porch, sync, back porch; the sync region is [ACTIVE+FP, ACTIVE+FP+SYNC-1].
REQ-019 SHALL register all outputs, updating them on the pix_en cycle, one clock after the counter value they describe; sync, DE, x, y and RGB SHALL stay mutually aligned.
REQ-020 SHALL drive DE=1 only when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; while DE=0, RGB SHALL be 0.
REQ-021 SHALL latch mode and solid_color only at h_cnt=0, v_cnt=0; changes made mid-frame take effect at the next frame start.
REQ-022 Colour bars SHALL use 8 equal bars of width H_ACTIVE/8 in this order: white, yellow, cyan, green, magenta, red, blue, black (full-scale components; integer-division remainder pixels black).
REQ-023 Checker SHALL output white when x[CELL_SHIFT] XOR y[CELL_SHIFT] is 1, otherwise black.
REQ-024 Grid SHALL output white when x[CELL_SHIFT-1:0]==0, y[CELL_SHIFT-1:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; otherwise it SHALL output the latched solid_color.
REQ-025 SHALL drive x and y as the coordinate during active video and hold them at 0 during blanking.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear the divide counter, h_cnt, v_cnt, DE, R, G, B, x, y and frame_start, and SHALL set latched mode to 0 and latched colour to 0.
REQ-027 During reset, HSYNC SHALL equal ~HS_POL and VSYNC SHALL equal ~VS_POL; after release, timing SHALL restart at pixel (0,0) of a new frame with no partial frame.

Structure
REQ-028 Package vga_pkg SHALL hold the mode encodings, the default 640x480@60 timing constants and the eight bar colour constants.
REQ-029 Sub-module vga_timing SHALL contain the divider, counters, sync/DE generation and coordinates; vga_pattern_gen SHALL add the mode latch and pattern/output registers.

Verification
REQ-030 Defaults, reset released: HSYNC period is 1600 clk, low for 192 clk, starting 1312 clk after the line start; frame period is 840000 clk.
REQ-031 Defaults: VSYNC is low for lines 490-491 only; DE is high 640 pixels per line on lines 0-479; frame_start pulses once per frame.
REQ-032 mode=1: x=0 gives R=31 G=63 B=31; x=80 gives 31/63/0; x=560 gives 0/0/0; blanking gives 0/0/0.
REQ-033 mode=2, CELL_SHIFT=5: (0,0) is black, (32,0) is white, (32,32) is black; mode=3 with solid_color=16'h001F gives (1,1) = 0/0/31 and (64,1) = white.
REQ-034 Switching mode 0->1 at line 200: the rest of that frame stays solid; bars appear from the next frame_start.
REQ-035 Reset pulse mid-line with CLK_DIV=3, HS_POL=1: outputs clear and HSYNC goes low asynchronously; after release the first HSYNC high occurs at pixel 656 of line 0.
